// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding (receiver and transmitter)
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4,
        PARITY    = 3'd5
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop rx synchroniser with falling-edge detect, flops reset to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, centre-sampled; UART_RX_PARITY_EN adds an even-parity bit and parity_err
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int             CW     = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  C_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     C_LAST = 3'(DATA_BITS - 1);

    uart_state_t          r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [2:0]           r_bit, w_bit;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [DATA_BITS-1:0] r_data, w_data;
    logic                 r_valid, w_valid;
    logic                 r_ferr, w_ferr;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad, w_par_bad;
    logic                 r_perr, w_perr;
`endif
    logic                 w_rx_s;
    logic                 w_fall;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .rx_s  (w_rx_s),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state;
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_data  = r_data;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad = r_par_bad;
        w_perr    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state = START;
                    w_cnt   = '0;
                end
            end
            START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == C_FULL) begin
                    w_cnt   = '0;
                    w_shift = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit   = r_bit + 3'd1;
                    if (r_bit == C_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state = PARITY;
`else
                        w_state = STOP;
`endif
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_cnt == C_FULL) begin
                    w_cnt     = '0;
                    w_par_bad = w_rx_s ^ (^r_shift);
                    w_state   = STOP;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (r_cnt == C_FULL) begin
                    w_cnt = '0;
                    if (w_rx_s) begin
                        // Leaving at the stop-bit centre lets an immediately following start bit be caught
                        w_state = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (r_par_bad) begin
                            w_perr = 1'b1;
                        end else begin
                            w_valid = 1'b1;
                            w_data  = r_shift;
                        end
`else
                        w_valid = 1'b1;
                        w_data  = r_shift;
`endif
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = WAIT_HIGH;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (w_rx_s) w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad;
            r_perr    <= w_perr;
`endif
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign frame_err = r_ferr;
    assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx at 16 clk per bit
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       tb_par_bit;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   vcyc[$];
    logic prev_v  = 1'b0;
    logic prev_fe = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic pop_and_check(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check("unexpected_pulse", 32'(kind) + 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pulse_kind", 32'(kind), 32'(e.kind));
            check("pulse_data", {24'd0, data_out}, {24'd0, e.data});
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (valid && frame_err) check("valid_ferr_exclusive", 32'd1, 32'd0);
            if (valid) begin
                check("valid_width", {31'd0, prev_v}, 32'd0);
                vcyc.push_back(cyc);
                pop_and_check(K_VALID);
            end
            if (frame_err) begin
                check("ferr_width", {31'd0, prev_fe}, 32'd0);
                pop_and_check(K_FERR);
            end
`ifdef UART_RX_PARITY_EN
            if (parity_err) begin
                if (valid) check("valid_perr_exclusive", 32'd1, 32'd0);
                pop_and_check(K_PERR);
            end
`endif
        end
        prev_v  = valid;
        prev_fe = frame_err;
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(tb_par_bit);
`endif
        if (stop) begin
            rx = 1'b1;
            repeat (9) @(negedge clk);
            check("busy_before_stop_centre", {31'd0, busy}, 32'd1);
            repeat (3) @(negedge clk);
            check("busy_after_stop_centre", {31'd0, busy}, 32'd0);
            repeat (CPB - 12) @(negedge clk);
        end else begin
            drive_bit(1'b0);
        end
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sb.push_back(e);
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        rx    = 1'b1;
`ifdef UART_RX_PARITY_EN
        tb_par_bit = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // single good frame
`ifdef UART_RX_PARITY_EN
        tb_par_bit = ^8'hAA;
`endif
        expect_pulse(K_VALID, 8'hAA);
        send_frame(8'hAA, 1'b1);
        repeat (CPB) @(negedge clk);
        check("aa_data_out", {24'd0, data_out}, 32'h0000_00AA);

        // back-to-back frames
        n0 = vcyc.size();
        expect_pulse(K_VALID, 8'h00);
        expect_pulse(K_VALID, 8'hFF);
`ifdef UART_RX_PARITY_EN
        tb_par_bit = 1'b0;
`endif
        send_frame(8'h00, 1'b1);
`ifdef UART_RX_PARITY_EN
        tb_par_bit = 1'b0;
`endif
        send_frame(8'hFF, 1'b1);
        repeat (CPB) @(negedge clk);
        check("b2b_pulse_count", 32'(vcyc.size() - n0), 32'd2);
        if (vcyc.size() - n0 == 2) begin
            int gap;
            gap = vcyc[n0 + 1] - vcyc[n0];
            check("b2b_gap_in_range", {31'd0, (gap >= 10 * CPB - 1 && gap <= 10 * CPB + 1 +
`ifdef UART_RX_PARITY_EN
                CPB
`else
                0
`endif
            ) ? 1'b1 : 1'b0}, 32'd1);
        end
        check("b2b_data_out", {24'd0, data_out}, 32'h0000_00FF);

        // short glitch on an idle line
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        repeat (CPB) @(negedge clk);

        // bad stop bit followed by a stuck-low line
        expect_pulse(K_FERR, 8'hFF);
`ifdef UART_RX_PARITY_EN
        tb_par_bit = ^8'h55;
`endif
        send_frame(8'h55, 1'b0);
        repeat (40 - CPB) @(negedge clk);
        check("break_still_busy", {31'd0, busy}, 32'd1);
        check("break_data_kept", {24'd0, data_out}, 32'h0000_00FF);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break_released_idle", {31'd0, busy}, 32'd0);
        repeat (CPB) @(negedge clk);

        // reset in the middle of 0x3C, then a clean 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'h3C >> i));
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        expect_pulse(K_VALID, 8'hC3);
`ifdef UART_RX_PARITY_EN
        tb_par_bit = ^8'hC3;
`endif
        send_frame(8'hC3, 1'b1);
        repeat (CPB) @(negedge clk);
        check("c3_data_out", {24'd0, data_out}, 32'h0000_00C3);

`ifdef UART_RX_PARITY_EN
        expect_pulse(K_VALID, 8'h07);
        tb_par_bit = 1'b1;
        send_frame(8'h07, 1'b1);
        expect_pulse(K_PERR, 8'h07);
        tb_par_bit = 1'b0;
        send_frame(8'h07, 1'b1);
        repeat (CPB) @(negedge clk);
        check("perr_data_kept", {24'd0, data_out}, 32'h0000_0007);
`endif

        repeat (4 * CPB) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the stage directly downstream of the UART transmitter.
- Consumes the serial line driven by the transmitter's tx output and recovers 8-bit frames: 1 start bit, 8 data bits LSB first, 1 stop bit (8N1).
- Oversamples each bit CLKS_PER_BIT times and samples at bit centre.
- Presents each good byte with a 1-cycle valid strobe, or a 1-cycle frame_err strobe on a bad stop bit.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit. Legal values ≥4; must match the transmitter's bit period.
- DATA_BITS, 8, data bits per frame. Fixed at 8 in this revision.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high. Asynchronous to clk.
- data_out  output  8  last correctly received byte.
- valid  output  1  1-cycle pulse; data_out updated this cycle.
- frame_err  output  1  1-cycle pulse; stop bit sampled low.
- busy  output  1  high while a frame is in progress (any state ≠ IDLE).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: data_out=0x00, valid=0, frame_err=0, busy=0, state=IDLE, bit counter=0, sample counter=0. Synchroniser flops reset to 1 (idle line).
- Input conditioning: rx passes through a 2-flop synchroniser to give rx_s. Falling edge = rx_s_prev=1 and rx_s=0.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on a falling edge go to START and clear the sample counter.
- START: count to CLKS_PER_BIT/2−1, then sample rx_s.
  - Sample 0: go to DATA, clear counters.
  - Sample 1: glitch; return to IDLE with no output.
- DATA: count to CLKS_PER_BIT−1, then sample rx_s into the shift register MSB and shift right (LSB first on the line). Bit counter increments. After the 8th sample go to STOP.
- STOP: count to CLKS_PER_BIT−1, then sample rx_s.
  - Sample 1: data_out<=shift register, valid=1 on the next cycle, go to IDLE.
  - Sample 0: frame_err=1 on the next cycle, data_out unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. Prevents a break or stuck-low line from re-triggering.
- Back-to-back frames: IDLE is entered at the stop-bit centre, so a start bit immediately following the stop bit is detected.
- Latency: valid asserts 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clk after the rx falling edge, ±1 for synchroniser phase.
- valid and frame_err are never high in the same cycle. Each is high for exactly one cycle per frame.
- Counters: the sample counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at each terminal count. The bit counter is 3 bits.
- Reset mid-frame: immediate return to reset values. Any partial byte is discarded with no strobe.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; it samples one even-parity bit.
  - An extra output parity_err (1 bit, reset 0) is added.
  - Parity mismatch with a good stop bit: parity_err pulses 1 cycle in place of valid, and data_out is not updated.
  - A bad stop bit still gives frame_err only.
- When undefined: 8N1 only, no PARITY state, no parity_err port.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants (IDLE, START, DATA, STOP, WAIT_HIGH, PARITY);
  - DATA_BITS=8;
  - default CLKS_PER_BIT=16.
  - The UART transmitter uses the same package.
- One sub-module, uart_rx_sync: 2-flop synchroniser plus falling-edge detector, with async active-low reset to 1. Outputs rx_s and fall.

Test Plan (CLKS_PER_BIT=16; the bench drives rx from a bit-accurate model or the transmitter):
- Send 0xAA 8N1 → exactly one valid pulse, data_out=0xAA, frame_err never high, busy falls at the stop-bit centre.
- Send 0x00 then 0xFF with no idle between frames → two valid pulses 160±1 clk apart, data_out 0x00 then 0xFF.
- Drive rx low for 4 clk, then high → no valid or frame_err, busy returns to 0 within 10 clk.
- Send 0x55 with stop bit forced 0, rx held low 40 clk, then high → one frame_err pulse; data_out keeps its previous value; no new frame until rx returns high.
- Assert rst_n low after the 4th data bit of 0x3C, release, then send 0xC3 → no output for 0x3C; valid with data_out=0xC3.
- With UART_RX_PARITY_EN defined: send 0x07 with parity bit 1 (correct) → valid with 0x07. Then send 0x07 with parity bit 0 → parity_err pulse, no valid, data_out remains 0x07.
